// File: rtl/fft_cfg_sequencer_if.sv
// Config channel between the sequencer and the FFT core's AXI-Stream config port.
interface fft_cfg_sequencer_if #(
  parameter int unsigned CFG_W = 16
);

  logic [CFG_W-1:0] m_axis_config_tdata;
  logic             m_axis_config_tvalid;
  logic             m_axis_config_tready;

  // Sequencer side drives the config word
  modport master (
    output m_axis_config_tdata,
    output m_axis_config_tvalid,
    input  m_axis_config_tready
  );

  // FFT core side accepts the config word
  modport slave (
    input  m_axis_config_tdata,
    input  m_axis_config_tvalid,
    output m_axis_config_tready
  );

endinterface

// File: rtl/fft_cfg_sequencer.sv
// Issues one FFT config word per job, then counts output samples and frames
// against the programmed transform size and reports busy/done/error status.
module fft_cfg_sequencer #(
  parameter int unsigned FRAMES_W = 16,
  parameter int unsigned MIN_NFFT = 3,
  parameter int unsigned MAX_NFFT = 16,
  parameter int unsigned CFG_W    = 16
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                ctrl_start,
  input  logic                ctrl_abort,
  input  logic [4:0]          cfg_nfft_log2,
  input  logic                cfg_fwd_inv,
  input  logic [FRAMES_W-1:0] cfg_frames,
  fft_cfg_sequencer_if.master cfg_if,
  input  logic                fft_out_tvalid,
  input  logic                fft_out_tready,
  input  logic                fft_out_tlast,
  input  logic                evt_tlast_err,
  output logic                busy,
  output logic                done,
  output logic [2:0]          err_code,
  output logic [FRAMES_W-1:0] frames_done,
  output logic                irq
);

  localparam int unsigned CNT_W = 17;

  localparam logic [4:0]          NFFT_MIN   = 5'(MIN_NFFT);
  localparam logic [4:0]          NFFT_MAX   = 5'(MAX_NFFT);
  localparam logic [FRAMES_W-1:0] FRAMES_MAX = '1;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_BAD_SIZE = 3'd1;
  localparam logic [2:0] ERR_EARLY    = 3'd2;
  localparam logic [2:0] ERR_MISSING  = 3'd3;
  localparam logic [2:0] ERR_CORE     = 3'd4;
  localparam logic [2:0] ERR_ABORT    = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CFG  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          nfft_q, nfft_d;
  logic [FRAMES_W-1:0] frames_q, frames_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [2:0]          err_q, err_d;
  logic [FRAMES_W-1:0] fd_q, fd_d;
  logic                irq_q, irq_d;
  logic                tvalid_q, tvalid_d;
  logic [CFG_W-1:0]    tdata_q, tdata_d;

  logic                beat_c;
  logic [CNT_W-1:0]    last_idx_c;
  logic                at_end_c;
  logic [FRAMES_W-1:0] fd_inc_c;

  assign beat_c     = fft_out_tvalid & fft_out_tready;
  assign last_idx_c = (CNT_W'(1) << nfft_q) - CNT_W'(1);
  assign at_end_c   = (cnt_q == last_idx_c);
  assign fd_inc_c   = (fd_q == FRAMES_MAX) ? fd_q : fd_q + FRAMES_W'(1);

  // State and status registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= IDLE;
      nfft_q   <= '0;
      frames_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= ERR_NONE;
      fd_q     <= '0;
      irq_q    <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      nfft_q   <= nfft_d;
      frames_q <= frames_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      fd_q     <= fd_d;
      irq_q    <= irq_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
    end
  end

  // Next-state, sample/frame counting and sticky first-error capture
  always_comb begin
    state_d  = state_q;
    nfft_d   = nfft_q;
    frames_d = frames_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    fd_d     = fd_q;
    irq_d    = 1'b0;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;

    case (state_q)
      IDLE: begin
        // abort beats start when both arrive together
        if (ctrl_start && !ctrl_abort) begin
          nfft_d   = cfg_nfft_log2;
          frames_d = cfg_frames;
          tdata_d  = CFG_W'({cfg_fwd_inv, 3'b000, cfg_nfft_log2});
          cnt_d    = '0;
          done_d   = 1'b0;
          err_d    = ERR_NONE;
          fd_d     = '0;
          if (cfg_nfft_log2 < NFFT_MIN || cfg_nfft_log2 > NFFT_MAX) begin
            done_d = 1'b1;
            err_d  = ERR_BAD_SIZE;
            irq_d  = 1'b1;
          end else if (cfg_frames == '0) begin
            done_d = 1'b1;
            irq_d  = 1'b1;
          end else begin
            state_d  = CFG;
            busy_d   = 1'b1;
            tvalid_d = 1'b1;
          end
        end
      end

      CFG: begin
        if (evt_tlast_err && err_d == ERR_NONE) err_d = ERR_CORE;
        if (cfg_if.m_axis_config_tready) begin
          tvalid_d = 1'b0;
          state_d  = RUN;
        end
      end

      RUN: begin
        if (beat_c) begin
          if (fft_out_tlast || at_end_c) begin
            if (!at_end_c) begin
              if (err_d == ERR_NONE) err_d = ERR_EARLY;
            end else if (!fft_out_tlast) begin
              if (err_d == ERR_NONE) err_d = ERR_MISSING;
            end
            cnt_d = '0;
            fd_d  = fd_inc_c;
            if (fd_inc_c == frames_q) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              irq_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (evt_tlast_err && err_d == ERR_NONE) err_d = ERR_CORE;
      end

      default: state_d = IDLE;
    endcase

    // Abort ends the job immediately and freezes the frame count
    if (ctrl_abort && state_q != IDLE) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      tvalid_d = 1'b0;
      done_d   = 1'b1;
      irq_d    = 1'b1;
      cnt_d    = '0;
      fd_d     = fd_q;
      err_d    = (err_q == ERR_NONE) ? ERR_ABORT : err_q;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err_code    = err_q;
  assign frames_done = fd_q;
  assign irq         = irq_q;

  assign cfg_if.m_axis_config_tvalid = tvalid_q;
  assign cfg_if.m_axis_config_tdata  = tdata_q;

endmodule

// File: tb/tb_fft_cfg_sequencer.sv
// Scoreboard bench: expected config words and job results are queued by the
// stimulus; a negedge monitor pops and compares on each handshake and irq.
module tb_fft_cfg_sequencer;

  localparam int unsigned FRAMES_W = 16;
  localparam int unsigned CFG_W    = 16;

  typedef struct packed {
    logic [2:0]          err;
    logic [FRAMES_W-1:0] fd;
  } irq_exp_t;

  logic                ACLK;
  logic                ARESET;
  logic                ctrl_start;
  logic                ctrl_abort;
  logic [4:0]          cfg_nfft_log2;
  logic                cfg_fwd_inv;
  logic [FRAMES_W-1:0] cfg_frames;
  logic                fft_out_tvalid;
  logic                fft_out_tready;
  logic                fft_out_tlast;
  logic                evt_tlast_err;
  logic                busy;
  logic                done;
  logic [2:0]          err_code;
  logic [FRAMES_W-1:0] frames_done;
  logic                irq;

  fft_cfg_sequencer_if #(.CFG_W(CFG_W)) cfg_if ();

  fft_cfg_sequencer #(
    .FRAMES_W(FRAMES_W),
    .MIN_NFFT(3),
    .MAX_NFFT(16),
    .CFG_W   (CFG_W)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .ctrl_start    (ctrl_start),
    .ctrl_abort    (ctrl_abort),
    .cfg_nfft_log2 (cfg_nfft_log2),
    .cfg_fwd_inv   (cfg_fwd_inv),
    .cfg_frames    (cfg_frames),
    .cfg_if        (cfg_if),
    .fft_out_tvalid(fft_out_tvalid),
    .fft_out_tready(fft_out_tready),
    .fft_out_tlast (fft_out_tlast),
    .evt_tlast_err (evt_tlast_err),
    .busy          (busy),
    .done          (done),
    .err_code      (err_code),
    .frames_done   (frames_done),
    .irq           (irq)
  );

  int total = 0;
  int bad   = 0;
  int hs_count  = 0;
  int irq_count = 0;
  int hs_base   = 0;
  int irq_base  = 0;
  logic irq_prev = 1'b0;

  logic [CFG_W-1:0] exp_cfg[$];
  irq_exp_t         exp_irq[$];
  logic [CFG_W-1:0] mon_cfg;
  irq_exp_t         mon_irq;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: config handshakes and completion pulses against the scoreboard
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (cfg_if.m_axis_config_tvalid && cfg_if.m_axis_config_tready) begin
        hs_count++;
        if (exp_cfg.size() == 0) begin
          total++;
          bad++;
          $display("FAIL cfg_unexpected: got tdata 0x%0h with nothing queued",
                   cfg_if.m_axis_config_tdata);
        end else begin
          mon_cfg = exp_cfg.pop_front();
          check("cfg_tdata", 32'(cfg_if.m_axis_config_tdata), 32'(mon_cfg));
        end
      end
      if (irq) begin
        irq_count++;
        check("irq_width", 32'(irq_prev), 32'd0);
        if (exp_irq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL irq_unexpected: got irq err=%0d fd=%0d with nothing queued",
                   err_code, frames_done);
        end else begin
          mon_irq = exp_irq.pop_front();
          check("irq_done", 32'(done), 32'd1);
          check("irq_busy", 32'(busy), 32'd0);
          check("irq_err", 32'(err_code), 32'(mon_irq.err));
          check("irq_frames_done", 32'(frames_done), 32'(mon_irq.fd));
        end
      end
    end
    irq_prev = irq;
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic start_job(input logic [4:0] nfft, input logic fwd, input logic [FRAMES_W-1:0] frames);
    hs_base       = hs_count;
    irq_base      = irq_count;
    cfg_nfft_log2 = nfft;
    cfg_fwd_inv   = fwd;
    cfg_frames    = frames;
    ctrl_start    = 1'b1;
    step();
    ctrl_start    = 1'b0;
  endtask

  task automatic wait_cfg(input string name);
    for (int i = 0; i < 20 && hs_count == hs_base; i++) step();
    check(name, 32'(hs_count - hs_base), 32'd1);
  endtask

  task automatic beat(input logic last);
    fft_out_tvalid = 1'b1;
    fft_out_tready = 1'b1;
    fft_out_tlast  = last;
    step();
    fft_out_tvalid = 1'b0;
    fft_out_tlast  = 1'b0;
  endtask

  task automatic frame(input int n, input logic last_at_end);
    for (int i = 1; i <= n; i++) beat(last_at_end && (i == n));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ARESET = 1'b1;
    ctrl_start = 1'b0;
    ctrl_abort = 1'b0;
    cfg_nfft_log2 = '0;
    cfg_fwd_inv = 1'b0;
    cfg_frames = '0;
    fft_out_tvalid = 1'b0;
    fft_out_tready = 1'b0;
    fft_out_tlast = 1'b0;
    evt_tlast_err = 1'b0;
    cfg_if.m_axis_config_tready = 1'b1;
    idle(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_code), 32'd0);
    check("rst_fd", 32'(frames_done), 32'd0);
    check("rst_tvalid", 32'(cfg_if.m_axis_config_tvalid), 32'd0);
    check("rst_tdata", 32'(cfg_if.m_axis_config_tdata), 32'd0);
    ARESET = 1'b0;
    idle(2);

    // Nominal: nfft=4 forward, 3 frames of 16
    exp_cfg.push_back(16'h0104);
    exp_irq.push_back('{err: 3'd0, fd: 16'd3});
    start_job(5'd4, 1'b1, 16'd3);
    check("nom_busy_start", 32'(busy), 32'd1);
    wait_cfg("nom_cfg_once");
    frame(16, 1'b1);
    frame(16, 1'b1);
    frame(15, 1'b0);
    check("nom_busy_before_last", 32'(busy), 32'd1);
    beat(1'b1);
    check("nom_busy_fall", 32'(busy), 32'd0);
    idle(3);
    check("nom_irq_count", 32'(irq_count - irq_base), 32'd1);
    check("nom_cfg_count", 32'(hs_count - hs_base), 32'd1);

    // Config backpressure: beats offered during CFG must be ignored
    cfg_if.m_axis_config_tready = 1'b0;
    exp_cfg.push_back(16'h0003);
    exp_irq.push_back('{err: 3'd0, fd: 16'd1});
    start_job(5'd3, 1'b0, 16'd1);
    for (int i = 0; i < 5; i++) begin
      beat(1'b1);
      check("bp_tvalid", 32'(cfg_if.m_axis_config_tvalid), 32'd1);
      check("bp_tdata", 32'(cfg_if.m_axis_config_tdata), 32'h0003);
    end
    check("bp_fd_hold", 32'(frames_done), 32'd0);
    cfg_if.m_axis_config_tready = 1'b1;
    wait_cfg("bp_cfg_once");
    frame(8, 1'b1);
    idle(2);

    // Early tlast on beat 5 then a proper frame
    exp_cfg.push_back(16'h0103);
    exp_irq.push_back('{err: 3'd2, fd: 16'd2});
    start_job(5'd3, 1'b1, 16'd2);
    wait_cfg("early_cfg");
    frame(5, 1'b1);
    frame(8, 1'b1);
    idle(2);

    // Missing tlast on a single frame
    exp_cfg.push_back(16'h0003);
    exp_irq.push_back('{err: 3'd3, fd: 16'd1});
    start_job(5'd3, 1'b0, 16'd1);
    wait_cfg("miss_cfg");
    frame(8, 1'b0);
    idle(2);

    // Missing tlast then a core event: first error stays
    exp_cfg.push_back(16'h0003);
    exp_irq.push_back('{err: 3'd3, fd: 16'd2});
    start_job(5'd3, 1'b0, 16'd2);
    wait_cfg("miss_evt_cfg");
    frame(8, 1'b0);
    evt_tlast_err = 1'b1;
    step();
    evt_tlast_err = 1'b0;
    check("miss_evt_err_hold", 32'(err_code), 32'd3);
    frame(8, 1'b1);
    idle(2);

    // Core event alone records error 4 and processing continues
    exp_cfg.push_back(16'h0103);
    exp_irq.push_back('{err: 3'd4, fd: 16'd1});
    start_job(5'd3, 1'b1, 16'd1);
    wait_cfg("evt_cfg");
    evt_tlast_err = 1'b1;
    step();
    evt_tlast_err = 1'b0;
    frame(8, 1'b1);
    idle(2);

    // Invalid size: no config issued
    exp_irq.push_back('{err: 3'd1, fd: 16'd0});
    start_job(5'd2, 1'b1, 16'd1);
    for (int i = 0; i < 3; i++) begin
      check("bad_tvalid", 32'(cfg_if.m_axis_config_tvalid), 32'd0);
      step();
    end
    exp_irq.push_back('{err: 3'd1, fd: 16'd0});
    start_job(5'd17, 1'b0, 16'd1);
    idle(3);
    check("bad_cfg_none", 32'(hs_count - hs_base), 32'd0);

    // Zero frames
    exp_irq.push_back('{err: 3'd0, fd: 16'd0});
    start_job(5'd5, 1'b1, 16'd0);
    idle(3);
    check("zero_cfg_none", 32'(hs_count - hs_base), 32'd0);

    // Abort after 10 beats
    exp_cfg.push_back(16'h0104);
    exp_irq.push_back('{err: 3'd5, fd: 16'd0});
    start_job(5'd4, 1'b1, 16'd2);
    wait_cfg("abort_cfg");
    frame(10, 1'b0);
    ctrl_abort = 1'b1;
    step();
    ctrl_abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    idle(2);

    // Abort during config backpressure
    cfg_if.m_axis_config_tready = 1'b0;
    exp_irq.push_back('{err: 3'd5, fd: 16'd0});
    start_job(5'd6, 1'b0, 16'd1);
    idle(2);
    ctrl_abort = 1'b1;
    step();
    ctrl_abort = 1'b0;
    check("abort_cfg_tvalid", 32'(cfg_if.m_axis_config_tvalid), 32'd0);
    cfg_if.m_axis_config_tready = 1'b1;
    idle(3);

    // Start and abort together: start ignored, status unchanged
    cfg_nfft_log2 = 5'd4;
    cfg_frames    = 16'd1;
    ctrl_start    = 1'b1;
    ctrl_abort    = 1'b1;
    step();
    ctrl_start    = 1'b0;
    ctrl_abort    = 1'b0;
    check("sa_busy", 32'(busy), 32'd0);
    check("sa_tvalid", 32'(cfg_if.m_axis_config_tvalid), 32'd0);
    check("sa_err_hold", 32'(err_code), 32'd5);
    idle(3);

    // Reset mid-run clears everything and nothing follows
    exp_cfg.push_back(16'h0003);
    start_job(5'd3, 1'b0, 16'd1);
    wait_cfg("rr_cfg");
    frame(3, 1'b0);
    ARESET = 1'b1;
    step();
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_done", 32'(done), 32'd0);
    check("rr_err", 32'(err_code), 32'd0);
    check("rr_fd", 32'(frames_done), 32'd0);
    check("rr_irq", 32'(irq), 32'd0);
    check("rr_tvalid", 32'(cfg_if.m_axis_config_tvalid), 32'd0);
    check("rr_tdata", 32'(cfg_if.m_axis_config_tdata), 32'd0);
    ARESET = 1'b0;
    frame(8, 1'b1);
    idle(3);
    check("rr_fd_after", 32'(frames_done), 32'd0);

    check("cfg_queue_empty", 32'(exp_cfg.size()), 32'd0);
    check("irq_queue_empty", 32'(exp_irq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
